// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALU opcodes, scoreboard entry and the scoreboard depth.
// Build option: define WB_BYPASS_EN when the register file is write-before-read (WB not tracked).
package pipeline_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    SLT  = 4'b0010,
    SLTU = 4'b0011,
    XOR  = 4'b0100,
    OR   = 4'b0101,
    AND  = 4'b0110,
    SLL  = 4'b0111,
    SRL  = 4'b1000,
    SRA  = 4'b1001,
    LUI  = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic       valid;
    logic       wren;
    logic [4:0] rd;
  } sb_entry_t;

  localparam sb_entry_t BUBBLE = '{valid: 1'b0, wren: 1'b0, rd: 5'd0};

`ifdef WB_BYPASS_EN
  localparam int SB_DEPTH = 2;
`else
  localparam int SB_DEPTH = 3;
`endif

  // x0 is hard-wired, so a read of it can never depend on an in-flight write.
  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] rs);
    return e.valid && e.wren && (rs != 5'd0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers of instructions in EX/MEM(/WB) and flags
// read-after-write hazards for the instruction sitting in decode.
module hazard_scoreboard
  import pipeline_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       head_accept_i,
  input  logic       head_wren_i,
  input  logic [4:0] head_rd_i,
  input  logic       id_valid_i,
  input  logic       use_rs1_i,
  input  logic [4:0] rs1_i,
  input  logic       use_rs2_i,
  input  logic [4:0] rs2_i,
  output logic       hazard_o
);

  sb_entry_t [SB_DEPTH-1:0] sb_q, sb_d;
  logic      [SB_DEPTH-1:0] hit_rs1, hit_rs2;

  always_comb begin
    sb_d = sb_q;
    sb_d[0] = head_accept_i ? '{valid: 1'b1, wren: head_wren_i, rd: head_rd_i} : BUBBLE;
    for (int i = 1; i < SB_DEPTH; i++) sb_d[i] = sb_q[i-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sb_q <= {SB_DEPTH{BUBBLE}};
    else       sb_q <= sb_d;
  end

  for (genvar g = 0; g < SB_DEPTH; g++) begin : g_cmp
    assign hit_rs1[g] = sb_hit(sb_q[g], rs1_i);
    assign hit_rs2[g] = sb_hit(sb_q[g], rs2_i);
  end

  assign hazard_o = id_valid_i & ((use_rs1_i & (|hit_rs1)) | (use_rs2_i & (|hit_rs2)));

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with RAW-hazard stall and branch flush.
// Build option WB_BYPASS_EN shortens the tracked window to EX/MEM (see pipeline_pkg).
module id_ex_hazard_reg
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [WIDTH-1:0] id_pc_i,
  input  logic [WIDTH-1:0] id_rs1_data_i,
  input  logic [WIDTH-1:0] id_rs2_data_i,
  input  logic [WIDTH-1:0] id_imm_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_rd_wren_i,
  input  logic             id_asel_pc_i,
  input  logic             id_bsel_imm_i,
  input  logic [3:0]       id_alu_control_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic             ex_rd_wren_o,
  output logic [WIDTH-1:0] ex_operand_a_o,
  output logic [WIDTH-1:0] ex_operand_b_o,
  output logic [WIDTH-1:0] ex_pc_o,
  output logic [WIDTH-1:0] ex_rs2_data_o,
  output logic [3:0]       ex_alu_control_o,
  output logic [4:0]       ex_rd_addr_o
);

  logic             hazard, accept;
  logic             ex_valid_q, ex_valid_d;
  logic             ex_wren_q, ex_wren_d;
  logic [WIDTH-1:0] ex_op_a_q, ex_op_a_d;
  logic [WIDTH-1:0] ex_op_b_q, ex_op_b_d;
  logic [WIDTH-1:0] ex_pc_q, ex_pc_d;
  logic [WIDTH-1:0] ex_rs2_q, ex_rs2_d;
  logic [3:0]       ex_alu_q, ex_alu_d;
  logic [4:0]       ex_rd_q, ex_rd_d;

  hazard_scoreboard u_sb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .head_accept_i (accept),
    .head_wren_i   (id_rd_wren_i),
    .head_rd_i     (id_rd_addr_i),
    .id_valid_i    (id_valid_i),
    .use_rs1_i     (id_use_rs1_i),
    .rs1_i         (id_rs1_addr_i),
    .use_rs2_i     (id_use_rs2_i),
    .rs2_i         (id_rs2_addr_i),
    .hazard_o      (hazard)
  );

  // Flush wins over a hazard: the decode instruction is dead, so no need to hold it.
  assign stall_o = hazard & ~flush_i;
  assign accept  = id_valid_i & ~hazard & ~flush_i;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_wren_d  = 1'b0;
    ex_op_a_d  = '0;
    ex_op_b_d  = '0;
    ex_pc_d    = '0;
    ex_rs2_d   = '0;
    ex_alu_d   = ADD;
    ex_rd_d    = '0;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_wren_d  = id_rd_wren_i;
      ex_op_a_d  = id_asel_pc_i  ? id_pc_i  : id_rs1_data_i;
      ex_op_b_d  = id_bsel_imm_i ? id_imm_i : id_rs2_data_i;
      ex_pc_d    = id_pc_i;
      ex_rs2_d   = id_rs2_data_i;
      ex_alu_d   = id_alu_control_i;
      ex_rd_d    = id_rd_addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_q <= 1'b0;
      ex_wren_q  <= 1'b0;
      ex_op_a_q  <= '0;
      ex_op_b_q  <= '0;
      ex_pc_q    <= '0;
      ex_rs2_q   <= '0;
      ex_alu_q   <= ADD;
      ex_rd_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_wren_q  <= ex_wren_d;
      ex_op_a_q  <= ex_op_a_d;
      ex_op_b_q  <= ex_op_b_d;
      ex_pc_q    <= ex_pc_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_alu_q   <= ex_alu_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign ex_valid_o       = ex_valid_q;
  assign ex_rd_wren_o     = ex_wren_q;
  assign ex_operand_a_o   = ex_op_a_q;
  assign ex_operand_b_o   = ex_op_b_q;
  assign ex_pc_o          = ex_pc_q;
  assign ex_rs2_data_o    = ex_rs2_q;
  assign ex_alu_control_o = ex_alu_q;
  assign ex_rd_addr_o     = ex_rd_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed vector table, mid-stall reset, then random
// traffic checked against a per-register "last write cycle" reference model.
module tb_id_ex_hazard_reg;
  import pipeline_pkg::*;

`ifdef WB_BYPASS_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 3;
`endif

  typedef struct {
    logic valid;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, wr, asel, bsel, flush;
    logic [31:0] rs1d, rs2d, pc, imm;
    logic [3:0] alu;
  } in_t;

  typedef struct {
    in_t in;
    logic stall, vld;
    logic [31:0] a, b, r2;
  } vec_t;

  logic clk = 0, rst = 1;
  logic id_valid, id_use_rs1, id_use_rs2, id_rd_wren, id_asel_pc, id_bsel_imm, flush;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0] id_alu;
  logic stall, ex_valid, ex_rd_wren;
  logic [31:0] ex_a, ex_b, ex_pc, ex_rs2;
  logic [3:0] ex_alu;
  logic [4:0] ex_rd;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int last_wr[32];

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr), .id_rd_addr_i(id_rd_addr),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_wren_i(id_rd_wren),
    .id_asel_pc_i(id_asel_pc), .id_bsel_imm_i(id_bsel_imm), .id_alu_control_i(id_alu),
    .flush_i(flush), .stall_o(stall), .ex_valid_o(ex_valid), .ex_rd_wren_o(ex_rd_wren),
    .ex_operand_a_o(ex_a), .ex_operand_b_o(ex_b), .ex_pc_o(ex_pc), .ex_rs2_data_o(ex_rs2),
    .ex_alu_control_o(ex_alu), .ex_rd_addr_o(ex_rd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic v, input logic [4:0] rs1, input logic u1, input logic [31:0] rs1d,
                             input logic [4:0] rs2, input logic u2, input logic [31:0] rs2d,
                             input logic [4:0] rd, input logic wr, input logic asel, input logic bsel,
                             input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] alu,
                             input logic fl);
    in_t r;
    r.valid = v; r.rs1 = rs1; r.u1 = u1; r.rs1d = rs1d; r.rs2 = rs2; r.u2 = u2; r.rs2d = rs2d;
    r.rd = rd; r.wr = wr; r.asel = asel; r.bsel = bsel; r.pc = pc; r.imm = imm; r.alu = alu;
    r.flush = fl;
    return r;
  endfunction

  task automatic apply(input in_t v);
    id_valid = v.valid; id_rs1_addr = v.rs1; id_use_rs1 = v.u1; id_rs1_data = v.rs1d;
    id_rs2_addr = v.rs2; id_use_rs2 = v.u2; id_rs2_data = v.rs2d; id_rd_addr = v.rd;
    id_rd_wren = v.wr; id_asel_pc = v.asel; id_bsel_imm = v.bsel; id_pc = v.pc;
    id_imm = v.imm; id_alu = v.alu; flush = v.flush;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) last_wr[i] = -1000;
  endtask

  // A register is busy for DEPTH cycles after the cycle its writer left decode.
  function automatic logic busy(input logic [4:0] r);
    return (r != 0) && ((cyc - last_wr[r]) <= DEPTH);
  endfunction

  task automatic cycle(input in_t v, output logic st_seen);
    logic hz, acc;
    apply(v);
    #2;
    hz  = v.valid && ((v.u1 && busy(v.rs1)) || (v.u2 && busy(v.rs2)));
    acc = v.valid && !hz && !v.flush;
    st_seen = stall;
    chk("stall", stall, hz && !v.flush);
    if (acc && v.wr) last_wr[v.rd] = cyc;
    cyc++;
    @(posedge clk); #1;
    chk("ex_valid", ex_valid, acc);
    chk("ex_rd_wren", ex_rd_wren, acc && v.wr);
    chk("ex_operand_a", ex_a, acc ? (v.asel ? v.pc : v.rs1d) : 32'd0);
    chk("ex_operand_b", ex_b, acc ? (v.bsel ? v.imm : v.rs2d) : 32'd0);
    chk("ex_pc", ex_pc, acc ? v.pc : 32'd0);
    chk("ex_rs2_data", ex_rs2, acc ? v.rs2d : 32'd0);
    chk("ex_alu_control", ex_alu, acc ? v.alu : 4'd0);
    chk("ex_rd_addr", ex_rd, acc ? v.rd : 5'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_valid"}, ex_valid, 0);
    chk({tag, "_wren"}, ex_rd_wren, 0);
    chk({tag, "_a"}, ex_a, 0);
    chk({tag, "_b"}, ex_b, 0);
    chk({tag, "_pc"}, ex_pc, 0);
    chk({tag, "_rs2"}, ex_rs2, 0);
    chk({tag, "_alu"}, ex_alu, 0);
    chk({tag, "_rd"}, ex_rd, 0);
  endtask

  vec_t tbl[18];

  initial begin
    logic st;
    in_t add6, sw, rd3, r;
    bit s3;
    s3 = (DEPTH == 3);
    model_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    @(posedge clk); #1;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 0;

    add6 = mk(1, 5, 1, 7, 5, 1, 7, 6, 1, 0, 0, 'h14, 0, ADD, 0);
    sw   = mk(1, 2, 1, 'h200, 5, 1, 'h55, 0, 0, 0, 1, 'h10c, 0, ADD, 0);
    tbl[0]  = '{mk(1, 0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 'h10, 7, ADD, 0), 0, 1, 0, 7, 0};
    tbl[1]  = '{add6, 1, 0, 0, 0, 0};
    tbl[2]  = '{add6, 1, 0, 0, 0, 0};
    tbl[3]  = '{add6, s3, !s3, s3 ? 0 : 7, s3 ? 0 : 7, s3 ? 0 : 7};
    tbl[4]  = '{add6, 0, 1, 7, 7, 7};
    tbl[5]  = '{mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 'h18, 1, ADD, 0), 0, 1, 0, 1, 0};
    tbl[6]  = '{mk(1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 'h1c, 0, ADD, 0), 0, 1, 0, 0, 0};
    tbl[7]  = '{mk(1, 0, 0, 'h1111, 0, 0, 'h2222, 7, 1, 1, 1, 'h100, 'h1000, ADD, 0),
                0, 1, 'h100, 'h1000, 'h2222};
    tbl[8]  = '{mk(1, 7, 1, 5, 0, 0, 0, 8, 1, 0, 0, 'h104, 0, SUB, 1), 0, 0, 0, 0, 0};
    tbl[9]  = '{mk(1, 0, 1, 0, 0, 0, 0, 2, 1, 0, 1, 'h108, 0, ADD, 0), 0, 1, 0, 0, 0};
    tbl[10] = '{sw, 1, 0, 0, 0, 0};
    tbl[11] = '{sw, 1, 0, 0, 0, 0};
    tbl[12] = '{sw, s3, !s3, s3 ? 0 : 'h200, 0, s3 ? 0 : 'h55};
    tbl[13] = '{sw, 0, 1, 'h200, 0, 'h55};
    tbl[14] = '{mk(1, 0, 1, 0, 0, 0, 0, 9, 1, 0, 1, 'h110, 3, ADD, 0), 0, 1, 0, 3, 0};
    tbl[15] = '{mk(0, 9, 1, 9, 9, 1, 9, 10, 1, 0, 0, 'h114, 0, ADD, 0), 0, 0, 0, 0, 0};
    tbl[16] = '{mk(1, 9, 1, 3, 0, 0, 0, 10, 1, 0, 0, 'h118, 0, XOR, 0), 1, 0, 0, 0, 0};
    tbl[17] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0};

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].in, st);
      chk($sformatf("tbl%0d_stall", i), st, tbl[i].stall);
      chk($sformatf("tbl%0d_valid", i), ex_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_a", i), ex_a, tbl[i].a);
      chk($sformatf("tbl%0d_b", i), ex_b, tbl[i].b);
      chk($sformatf("tbl%0d_rs2", i), ex_rs2, tbl[i].r2);
    end

    // Reset in the middle of a stall discards the hazard
    cycle(mk(1, 0, 1, 0, 0, 0, 0, 3, 1, 0, 1, 'h200, 4, ADD, 0), st);
    rd3 = mk(1, 3, 1, 4, 0, 0, 0, 11, 1, 0, 0, 'h204, 0, OR, 0);
    apply(rd3);
    #2;
    chk("rst_pre_stall", stall, 1);
    rst = 1;
    #1;
    chk_zero("rst_async");
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
    cycle(rd3, st);
    chk("rst_release_stall", st, 0);
    chk("rst_release_valid", ex_valid, 1);
    chk("rst_release_a", ex_a, 4);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      r = mk($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 1'($urandom), $urandom,
             5'($urandom_range(0, 7)), 1'($urandom), $urandom,
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, 4'($urandom_range(0, 10)), $urandom_range(0, 9) == 0);
      cycle(r, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
